// File: rtl/mem_access_unit.sv
// MIPS-style load/store unit: validates a CPU request, issues one aligned word access,
// merges/extends the returned word and answers on a response channel, with a watchdog.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] Address,
  output logic              MemWrite,
  output logic              MemRead,
  output logic [31:0]       Write_data,
  output logic [3:0]        Write_strb,
  input  logic              Mem_Req_Ready,
  input  logic [31:0]       Read_data,
  input  logic              Read_data_Valid,
  output logic              Read_data_Ready
);

  localparam logic [3:0] S_IDLE = 4'b0001;
  localparam logic [3:0] S_REQ  = 4'b0010;
  localparam logic [3:0] S_WAIT = 4'b0100;
  localparam logic [3:0] S_RESP = 4'b1000;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  logic [3:0]        state_q, state_d;
  logic              store_q, store_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              illegal, expired;
  logic [3:0]        st_strb;
  logic [31:0]       st_data, ld_data;

  always_comb begin
    illegal = 1'b0;
    if (req_op == 3'b111) illegal = 1'b1;
    if (req_store && (req_op == 3'b100 || req_op == 3'b101)) illegal = 1'b1;
    if ((req_op == 3'b001 || req_op == 3'b101) && req_addr[0]) illegal = 1'b1;
    if (req_op == 3'b011 && req_addr[1:0] != 2'b00) illegal = 1'b1;
  end

  // Fires on the last permitted wait cycle; a handshake in that cycle still wins.
  assign expired = (TIMEOUT > 0) && (cnt_q >= CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      store_q <= 1'b0;
      op_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid) state_d = illegal ? S_RESP : S_REQ;
      S_REQ: begin
        if (Mem_Req_Ready) state_d = store_q ? S_RESP : S_WAIT;
        else if (expired)  state_d = S_RESP;
      end
      S_WAIT: if (Read_data_Valid || expired) state_d = S_RESP;
      S_RESP: if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    store_d = store_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        store_d = req_store;
        op_d    = req_op;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rdata_d = '0;
        err_d   = illegal;
        cnt_d   = '0;
      end
      S_REQ: begin
        if (!expired) cnt_d = cnt_q + 1'b1;
        if (!Mem_Req_Ready && expired) err_d = 1'b1;
      end
      S_WAIT: begin
        if (!expired) cnt_d = cnt_q + 1'b1;
        if (Read_data_Valid) rdata_d = ld_data;
        else if (expired)    err_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    logic [1:0] a;
    logic [4:0] sh_a, sh_na;
    a      = addr_q[1:0];
    sh_a   = {a, 3'b000};
    sh_na  = {~a, 3'b000};
    st_strb = 4'b0000;
    st_data = 32'h0;
    case (op_q)
      3'b000: begin st_strb = 4'b0001 << a; st_data = {4{wdata_q[7:0]}}; end
      3'b001: begin st_strb = a[1] ? 4'b1100 : 4'b0011; st_data = {2{wdata_q[15:0]}}; end
      3'b011: begin st_strb = 4'b1111; st_data = wdata_q; end
      3'b010: begin st_strb = 4'b1111 >> (~a); st_data = wdata_q >> sh_na; end
      3'b110: begin st_strb = 4'b1111 << a; st_data = wdata_q << sh_a; end
      default: ;
    endcase
  end

  always_comb begin
    logic [4:0]  sh_a, sh_na;
    logic [5:0]  sh_lo;
    logic [31:0] m_sh;
    logic [15:0] half;
    sh_a  = {addr_q[1:0], 3'b000};
    sh_na = {~addr_q[1:0], 3'b000};
    sh_lo = {1'b0, sh_a} + 6'd8;
    m_sh  = Read_data >> sh_a;
    half  = addr_q[1] ? Read_data[31:16] : Read_data[15:0];
    case (op_q)
      3'b000:  ld_data = {{24{m_sh[7]}}, m_sh[7:0]};
      3'b100:  ld_data = {24'h0, m_sh[7:0]};
      3'b001:  ld_data = {{16{half[15]}}, half};
      3'b101:  ld_data = {16'h0, half};
      3'b010:  ld_data = (Read_data << sh_na) | (wdata_q & (32'hFFFF_FFFF >> sh_lo));
      3'b110:  ld_data = m_sh | (wdata_q & ~(32'hFFFF_FFFF >> sh_a));
      default: ld_data = Read_data;
    endcase
  end

  always_comb begin
    req_ready       = (state_q == S_IDLE);
    MemRead         = (state_q == S_REQ) && !store_q;
    MemWrite        = (state_q == S_REQ) && store_q;
    Read_data_Ready = (state_q == S_WAIT);
    resp_valid      = (state_q == S_RESP);
    resp_rdata      = rdata_q;
    resp_err        = err_q;
    Address         = {addr_q[ADDR_W-1:2], 2'b00};
    Write_strb      = MemWrite ? st_strb : 4'b0000;
    Write_data      = MemWrite ? st_data : 32'h0;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, illegal requests, watchdog and reset abort.
module tb_mem_access_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, req_store, resp_valid, resp_ready, resp_err;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata, resp_rdata, Address, Write_data, Read_data;
  logic        MemWrite, MemRead, Mem_Req_Ready, Read_data_Valid, Read_data_Ready;
  logic [3:0]  Write_strb;
  int n_vec = 0;
  int n_err = 0;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err), .Address(Address),
    .MemWrite(MemWrite), .MemRead(MemRead), .Write_data(Write_data), .Write_strb(Write_strb),
    .Mem_Req_Ready(Mem_Req_Ready), .Read_data(Read_data), .Read_data_Valid(Read_data_Valid),
    .Read_data_Ready(Read_data_Ready));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic st, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_store = st; req_op = op; req_addr = addr; req_wdata = wd;
    step;
    req_valid = 1'b0;
  endtask

  // Runs one access with an always-ready memory and records what was observed.
  task automatic do_access(input logic st, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] rt, input logic [31:0] m,
                           output logic [31:0] rd, output logic er, output int lat,
                           output logic [3:0] strb, output logic [31:0] wd,
                           output logic [31:0] a_seen, output logic req_seen);
    Mem_Req_Ready = 1'b1; resp_ready = 1'b1; Read_data = m; Read_data_Valid = 1'b0;
    rd = 32'h0; er = 1'b0; lat = -1; strb = 4'h0; wd = 32'h0; a_seen = 32'h0; req_seen = 1'b0;
    issue(st, op, addr, rt);
    for (int c = 1; c <= 20; c++) begin
      if ((MemRead || MemWrite) && !req_seen) begin
        req_seen = 1'b1; strb = Write_strb; wd = Write_data; a_seen = Address;
      end
      if (resp_valid) begin
        rd = resp_rdata; er = resp_err; lat = c;
        break;
      end
      Read_data_Valid = Read_data_Ready;
      step;
    end
    Read_data_Valid = 1'b0;
    step;
    $display("txn st=%0b op=%b addr=%h rt=%h m=%h -> rdata=%h err=%0b lat=%0d strb=%b wdata=%h",
             st, op, addr, rt, m, rd, er, lat, strb, wd);
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_op = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
    resp_ready = 1'b1; Mem_Req_Ready = 1'b0; Read_data = 32'h0; Read_data_Valid = 1'b0;
    step; step;
    rst = 1'b0;
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    n_vec++; if (MemRead !== 1'b0) begin n_err++; $display("FAIL rst_MemRead: got %b want 0", MemRead); end
    n_vec++; if (MemWrite !== 1'b0) begin n_err++; $display("FAIL rst_MemWrite: got %b want 0", MemWrite); end
    n_vec++; if (Read_data_Ready !== 1'b0) begin n_err++; $display("FAIL rst_rd_ready: got %b want 0", Read_data_Ready); end
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    n_vec++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL rst_resp_err: got %b want 0", resp_err); end
    n_vec++; if (Address !== 32'h0) begin n_err++; $display("FAIL rst_Address: got %h want 0", Address); end
    n_vec++; if (Write_data !== 32'h0) begin n_err++; $display("FAIL rst_Write_data: got %h want 0", Write_data); end
    n_vec++; if (Write_strb !== 4'h0) begin n_err++; $display("FAIL rst_Write_strb: got %b want 0", Write_strb); end
    n_vec++; if (resp_rdata !== 32'h0) begin n_err++; $display("FAIL rst_resp_rdata: got %h want 0", resp_rdata); end
  endtask

  task automatic test_lw;
    logic [31:0] rd, wd, a; logic er, seen; logic [3:0] sb; int lat;
    do_access(1'b0, 3'b011, 32'h100, 32'h0, 32'h8899AABB, rd, er, lat, sb, wd, a, seen);
    n_vec++; if (a !== 32'h100) begin n_err++; $display("FAIL lw_Address: got %h want 00000100", a); end
    n_vec++; if (rd !== 32'h8899AABB) begin n_err++; $display("FAIL lw_rdata: got %h want 8899aabb", rd); end
    n_vec++; if (er !== 1'b0) begin n_err++; $display("FAIL lw_err: got %b want 0", er); end
    n_vec++; if (lat != 3) begin n_err++; $display("FAIL lw_latency: got %0d want 3", lat); end
  endtask

  task automatic test_loads;
    logic [2:0]  ops [9] = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b101, 3'b110, 3'b110, 3'b010, 3'b000};
    logic [31:0] adr [9] = '{32'h103, 32'h103, 32'h101, 32'h102, 32'h100, 32'h101, 32'h100, 32'h103, 32'h100};
    logic [31:0] exp [9] = '{32'hFFFFFF80, 32'h00000080, 32'h22333344, 32'hFFFF8011, 32'h00002233,
                             32'h11801122, 32'h80112233, 32'h80112233, 32'h00000033};
    logic [31:0] rd, wd, a; logic er, seen; logic [3:0] sb; int lat;
    for (int i = 0; i < 9; i++) begin
      do_access(1'b0, ops[i], adr[i], 32'h11223344, 32'h80112233, rd, er, lat, sb, wd, a, seen);
      n_vec++; if (rd !== exp[i]) begin n_err++; $display("FAIL load%0d_rdata: got %h want %h", i, rd, exp[i]); end
      n_vec++; if (er !== 1'b0 || lat != 3) begin n_err++; $display("FAIL load%0d_err_lat: got err=%b lat=%0d want 0/3", i, er, lat); end
      n_vec++; if (a !== {adr[i][31:2], 2'b00}) begin n_err++; $display("FAIL load%0d_Address: got %h want %h", i, a, {adr[i][31:2], 2'b00}); end
    end
  endtask

  task automatic test_stores;
    logic [2:0]  ops [7] = '{3'b110, 3'b001, 3'b000, 3'b010, 3'b011, 3'b110, 3'b010};
    logic [31:0] adr [7] = '{32'h202, 32'h202, 32'h201, 32'h201, 32'h200, 32'h200, 32'h202};
    logic [3:0]  es  [7] = '{4'b1100, 4'b1100, 4'b0010, 4'b0011, 4'b1111, 4'b1111, 4'b0111};
    logic [31:0] ed  [7] = '{32'hCCDD0000, 32'hCCDDCCDD, 32'hDDDDDDDD, 32'h0000AABB,
                             32'hAABBCCDD, 32'hAABBCCDD, 32'h00AABBCC};
    logic [31:0] rd, wd, a; logic er, seen; logic [3:0] sb; int lat;
    for (int i = 0; i < 7; i++) begin
      do_access(1'b1, ops[i], adr[i], 32'hAABBCCDD, 32'h0, rd, er, lat, sb, wd, a, seen);
      n_vec++; if (sb !== es[i]) begin n_err++; $display("FAIL store%0d_strb: got %b want %b", i, sb, es[i]); end
      n_vec++; if (wd !== ed[i]) begin n_err++; $display("FAIL store%0d_wdata: got %h want %h", i, wd, ed[i]); end
      n_vec++; if (a !== 32'h200) begin n_err++; $display("FAIL store%0d_Address: got %h want 00000200", i, a); end
      n_vec++; if (seen !== 1'b1 || er !== 1'b0 || rd !== 32'h0 || lat != 2)
        begin n_err++; $display("FAIL store%0d_resp: got seen=%b err=%b rdata=%h lat=%0d want 1/0/0/2", i, seen, er, rd, lat); end
    end
  endtask

  task automatic test_illegal;
    logic        sts [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0]  ops [6] = '{3'b011, 3'b001, 3'b111, 3'b100, 3'b101, 3'b011};
    logic [31:0] adr [6] = '{32'h201, 32'h101, 32'h100, 32'h100, 32'h100, 32'h102};
    logic [31:0] rd, wd, a; logic er, seen; logic [3:0] sb; int lat;
    for (int i = 0; i < 6; i++) begin
      do_access(sts[i], ops[i], adr[i], 32'h55AA55AA, 32'h12345678, rd, er, lat, sb, wd, a, seen);
      n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL illegal%0d_no_access: got %b want 0", i, seen); end
      n_vec++; if (er !== 1'b1 || rd !== 32'h0 || lat != 1)
        begin n_err++; $display("FAIL illegal%0d_resp: got err=%b rdata=%h lat=%0d want 1/0/1", i, er, rd, lat); end
    end
    do_access(1'b0, 3'b011, 32'h104, 32'h0, 32'h12345678, rd, er, lat, sb, wd, a, seen);
    n_vec++; if (rd !== 32'h12345678 || er !== 1'b0 || lat != 3)
      begin n_err++; $display("FAIL after_illegal_lw: got rdata=%h err=%b lat=%0d want 12345678/0/3", rd, er, lat); end
  endtask

  task automatic test_timeout;
    int n;
    Mem_Req_Ready = 1'b0; resp_ready = 1'b0; Read_data_Valid = 1'b0;
    issue(1'b0, 3'b011, 32'h300, 32'h0);
    n = 0;
    while (MemRead === 1'b1 && n < 20) begin n++; step; end
    n_vec++; if (n != TO) begin n_err++; $display("FAIL timeout_memread_cycles: got %0d want %0d", n, TO); end
    n_vec++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0)
      begin n_err++; $display("FAIL timeout_resp: got v=%b err=%b rdata=%h want 1/1/0", resp_valid, resp_err, resp_rdata); end
    for (int k = 0; k < 3; k++) begin
      Mem_Req_Ready = 1'b1; Read_data_Valid = 1'b1; Read_data = 32'hFFFFFFFF;
      step;
      n_vec++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0 || MemRead !== 1'b0)
        begin n_err++; $display("FAIL hold%0d: got v=%b err=%b rdata=%h rd=%b want 1/1/0/0", k, resp_valid, resp_err, resp_rdata, MemRead); end
    end
    Mem_Req_Ready = 1'b0; Read_data_Valid = 1'b0; resp_ready = 1'b1;
    step;
    n_vec++; if (req_ready !== 1'b1 || resp_valid !== 1'b0)
      begin n_err++; $display("FAIL timeout_release: got ready=%b v=%b want 1/0", req_ready, resp_valid); end
  endtask

  task automatic test_timeout_priority;
    Mem_Req_Ready = 1'b0; resp_ready = 1'b1; Read_data_Valid = 1'b0;
    issue(1'b0, 3'b011, 32'h304, 32'h0);
    step; step; step;
    n_vec++; if (MemRead !== 1'b1) begin n_err++; $display("FAIL prio_memread_last: got %b want 1", MemRead); end
    Mem_Req_Ready = 1'b1;
    step;
    Mem_Req_Ready = 1'b0;
    n_vec++; if (Read_data_Ready !== 1'b1 || resp_valid !== 1'b0)
      begin n_err++; $display("FAIL prio_wait_rd: got rdy=%b v=%b want 1/0", Read_data_Ready, resp_valid); end
    Read_data = 32'hCAFEF00D; Read_data_Valid = 1'b1;
    step;
    Read_data_Valid = 1'b0;
    n_vec++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'hCAFEF00D)
      begin n_err++; $display("FAIL prio_resp: got v=%b err=%b rdata=%h want 1/0/cafef00d", resp_valid, resp_err, resp_rdata); end
    step;
  endtask

  task automatic test_reset_inflight;
    Mem_Req_Ready = 1'b1; resp_ready = 1'b1; Read_data_Valid = 1'b0;
    issue(1'b0, 3'b011, 32'h400, 32'h0);
    step;
    Mem_Req_Ready = 1'b0;
    n_vec++; if (Read_data_Ready !== 1'b1) begin n_err++; $display("FAIL abort_in_wait: got %b want 1", Read_data_Ready); end
    rst = 1'b1;
    step;
    rst = 1'b0;
    n_vec++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || Read_data_Ready !== 1'b0 || MemRead !== 1'b0)
      begin n_err++; $display("FAIL abort_idle: got ready=%b v=%b rdy=%b rd=%b want 1/0/0/0", req_ready, resp_valid, Read_data_Ready, MemRead); end
    Read_data = 32'hDEADBEEF; Read_data_Valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step;
      n_vec++; if (resp_valid !== 1'b0 || req_ready !== 1'b1)
        begin n_err++; $display("FAIL late_valid%0d: got v=%b ready=%b want 0/1", k, resp_valid, req_ready); end
    end
    Read_data_Valid = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_lw;
    test_loads;
    test_stores;
    test_illegal;
    test_timeout;
    test_timeout_priority;
    test_reset_inflight;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
